serial_pattern_source: RTL and testbench

//  Stimulus stage driving the sequence detector's sig_to_test input on the board.

---
 rtl/seq_pkg.sv | 14 +
 rtl/serial_pattern_source_tick_gen.sv | 33 +++
 rtl/serial_pattern_source.sv | 169 ++++++++++++++++
 tb/tb_serial_pattern_source.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types and constants for the board's serial stimulus path.
package seq_pkg;

   // Pattern source FSM states.
   typedef enum logic [1:0] {
      SRC_IDLE,
      SRC_SHIFT,
      SRC_DONE
   } src_state_t;

   // Line level while no pattern is being sent; keeps the detector in its start state.
   localparam logic SRC_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/serial_pattern_source_tick_gen.sv
// Bit-period prescaler: counts 0..DIV-1 while enabled and strobes tick on the
// last count, then wraps. clr restarts the period so a new bit always gets a
// full DIV clocks.
module tick_gen #(
   parameter int DIV = 50_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic ena,
   input  logic clr,
   output logic tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q;

   assign tick = ena && (cnt_q == LAST);

   // Period counter: restart on clr, hold while disabled, wrap after the last count.
   always_ff @(posedge clk) begin
      // NOTE: registers are written with <= so every flop samples the pre-edge values.
      if (rst) begin
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (ena) begin
         cnt_q <= tick ? '0 : cnt_q + CW'(1);
      end
   end

endmodule

// File: rtl/serial_pattern_source.sv
// Serial pattern source feeding the sequence detector's sig_to_test input.
// A load captures up to WIDTH switch bits and shifts them out MSB-first, each
// bit held DIV clocks, with a per-bit strobe and an end-of-pattern done pulse.
// The line idles high.
// Optional build macro SERIAL_SRC_LOOP_EN: adds loop_mode, which replays the
// captured pattern continuously (done pulses once per pass) until stop or rst.
module serial_pattern_source
   import seq_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIV   = 50_000_000,
   parameter int LEN_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  logic             load,
`ifdef SERIAL_SRC_LOOP_EN
   input  logic             loop_mode,
`endif
   input  logic [WIDTH-1:0] pattern,
   input  logic [LEN_W-1:0] len,
   input  logic             stop,
   output logic             sig_out,
   output logic             bit_valid,
   output logic             busy,
   output logic             done,
   output logic [LEN_W-1:0] bits_left
);

   localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);

   src_state_t       state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [LEN_W-1:0] bits_left_q, bits_left_d;
   logic             bv_q, bv_d;

   logic             tick;
   logic             accept;
   logic             reload;
   logic [LEN_W-1:0] len_eff;
   logic [WIDTH-1:0] aligned;

   // Oversized lengths clamp to the register width; the first bit to send is
   // moved to the MSB so shifting left always presents the next bit.
   assign len_eff = (len > WIDTH_L) ? WIDTH_L : len;
   assign aligned = pattern << (WIDTH_L - len_eff);

`ifdef SERIAL_SRC_LOOP_EN
   logic [WIDTH-1:0] pat_cap_q;
   logic [LEN_W-1:0] len_cap_q;
   logic             done_loop_q, done_loop_d;
`endif

   tick_gen #(
      .DIV (DIV)
   ) u_tick_gen (
      .clk  (clk),
      .rst  (rst),
      .ena  (ena),
      .clr  (accept | reload),
      .tick (tick)
   );

   // Next-state logic: accept, per-bit shift, abort and completion.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path infers a latch.
      state_d     = state_q;
      shreg_d     = shreg_q;
      bits_left_d = bits_left_q;
      bv_d        = bv_q;
      accept      = 1'b0;
      reload      = 1'b0;
`ifdef SERIAL_SRC_LOOP_EN
      done_loop_d = done_loop_q;
`endif
      if (ena) begin
         bv_d = 1'b0;
`ifdef SERIAL_SRC_LOOP_EN
         done_loop_d = 1'b0;
`endif
         case (state_q)
            SRC_IDLE: begin
               // stop has priority over load; a zero-length request is ignored.
               if (load && !stop && (len_eff != '0)) begin
                  accept      = 1'b1;
                  state_d     = SRC_SHIFT;
                  shreg_d     = aligned;
                  bits_left_d = len_eff - LEN_W'(1);
                  bv_d        = 1'b1;
               end
            end
            SRC_SHIFT: begin
               if (stop) begin
                  state_d     = SRC_IDLE;
                  bits_left_d = '0;
               end else if (tick) begin
                  if (bits_left_q != '0) begin
                     shreg_d     = shreg_q << 1;
                     bits_left_d = bits_left_q - LEN_W'(1);
                     bv_d        = 1'b1;
                  end
`ifdef SERIAL_SRC_LOOP_EN
                  else if (loop_mode) begin
                     reload      = 1'b1;
                     shreg_d     = pat_cap_q;
                     bits_left_d = len_cap_q - LEN_W'(1);
                     bv_d        = 1'b1;
                     done_loop_d = 1'b1;
                  end
`endif
                  else begin
                     state_d = SRC_DONE;
                  end
               end
            end
            SRC_DONE: begin
               state_d = SRC_IDLE;
            end
            default: begin
               state_d = SRC_IDLE;
            end
         endcase
      end
   end

   // State, shift register, remaining-bit count and strobe registers.
   always_ff @(posedge clk) begin
      // NOTE: the data shift register is reset too; it is only a few flops and keeps sig_out defined.
      if (rst) begin
         state_q     <= SRC_IDLE;
         shreg_q     <= '0;
         bits_left_q <= '0;
         bv_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         shreg_q     <= shreg_d;
         bits_left_q <= bits_left_d;
         bv_q        <= bv_d;
      end
   end

`ifdef SERIAL_SRC_LOOP_EN
   // Copy of the accepted pattern/length for replay, plus the per-pass done flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         pat_cap_q   <= '0;
         len_cap_q   <= '0;
         done_loop_q <= 1'b0;
      end else begin
         if (accept) begin
            pat_cap_q <= aligned;
            len_cap_q <= len_eff;
         end
         done_loop_q <= done_loop_d;
      end
   end

   assign done = ena && ((state_q == SRC_DONE) || done_loop_q);
`else
   assign done = ena && (state_q == SRC_DONE);
`endif

   assign sig_out   = (state_q == SRC_SHIFT) ? shreg_q[WIDTH-1] : SRC_IDLE_LEVEL;
   assign bit_valid = ena && bv_q;
   assign busy      = (state_q == SRC_SHIFT);
   assign bits_left = bits_left_q;

endmodule

// File: tb/tb_serial_pattern_source.sv
// Bench for serial_pattern_source (WIDTH=16, DIV=4). Expected outputs come from
// a cycle model: after a load, the j-th enabled clock presents bit j/DIV of the
// pattern (MSB first), strobes on j%DIV==0, and pulses done at j==len*DIV.
module tb_serial_pattern_source;

   localparam int WIDTH = 16;
   localparam int DIV   = 4;
   localparam int LEN_W = 5;

   logic             clk;
   logic             rst;
   logic             ena;
   logic             load;
   logic             stop;
   logic [WIDTH-1:0] pattern;
   logic [LEN_W-1:0] len;
   logic             sig_out;
   logic             bit_valid;
   logic             busy;
   logic             done;
   logic [LEN_W-1:0] bits_left;
`ifdef SERIAL_SRC_LOOP_EN
   logic             loop_mode;
`endif

   int n_total;
   int n_pass;

   logic [8:0] obs_v;
   assign obs_v = {sig_out, bit_valid, busy, done, bits_left};

   localparam logic [8:0] IDLE_V = 9'b1_0_0_0_00000;

   serial_pattern_source #(
      .WIDTH (WIDTH),
      .DIV   (DIV),
      .LEN_W (LEN_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .ena       (ena),
      .load      (load),
`ifdef SERIAL_SRC_LOOP_EN
      .loop_mode (loop_mode),
`endif
      .pattern   (pattern),
      .len       (len),
      .stop      (stop),
      .sig_out   (sig_out),
      .bit_valid (bit_valid),
      .busy      (busy),
      .done      (done),
      .bits_left (bits_left)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Runs one transaction: cycle 0 is the load cycle (current cycle on entry).
   // Optional events (negative = unused): stop, rst, an ena-low window and a
   // second load during the transfer. Every following cycle is compared.
   task automatic drive_frame(input string name, input logic [15:0] pat, input int len_in,
                              input int stop_at, input int rst_at, input int ena_off_at,
                              input int ena_off_n, input int reload_at, input int extra);
      int l, j, idx, last_k;
      bit aborted, ena_prev, stop_prev, rst_prev;
      logic [8:0] e;
      l = (len_in > WIDTH) ? WIDTH : len_in;
      pattern = pat;
      len     = LEN_W'(len_in);
      load    = 1'b1;
      stop    = 1'b0;
      ena     = 1'b1;
      rst     = 1'b0;
      j = 0;
      aborted = 1'b0;
      ena_prev = 1'b1;
      stop_prev = 1'b0;
      rst_prev = 1'b0;
      last_k = l * DIV + 1 + ena_off_n + extra;
      for (int k = 1; k <= last_k; k++) begin
         @(posedge clk);
         #1;
         if (k > 1) begin
            if (rst_prev) aborted = 1'b1;
            else if (ena_prev && !aborted) begin
               if (stop_prev && j < l * DIV) aborted = 1'b1;
               else j++;
            end
         end
         load = (k == reload_at);
         if (load) begin
            pattern = ~pat;
            len     = 5'd3;
         end
         ena  = !(ena_off_at >= 0 && k >= ena_off_at && k < ena_off_at + ena_off_n);
         stop = (k == stop_at);
         rst  = (k == rst_at);
         ena_prev  = ena;
         stop_prev = stop;
         rst_prev  = rst;
         #1;
         if (aborted || j > l * DIV) begin
            e = IDLE_V;
         end else if (j == l * DIV) begin
            e = {1'b1, 1'b0, 1'b0, ena, 5'd0};
         end else begin
            idx = j / DIV;
            e = {pat[l-1-idx], (j % DIV == 0) && ena, 1'b1, 1'b0, LEN_W'(l - 1 - idx)};
         end
         n_total++;
         if (obs_v !== e)
            $display("FAIL %s cyc%0d: sig/bv/busy/done/left got %b want %b", name, k, obs_v, e);
         else
            n_pass++;
      end
      load = 1'b0;
      stop = 1'b0;
      ena  = 1'b1;
      rst  = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_total++;
      if (obs_v !== IDLE_V) $display("FAIL reset_values: got %b want %b", obs_v, IDLE_V);
      else n_pass++;
      rst = 1'b0;
      @(posedge clk);
      #2;
      n_total++;
      if (obs_v !== IDLE_V) $display("FAIL after_reset_idle: got %b want %b", obs_v, IDLE_V);
      else n_pass++;
   endtask

   task automatic test_frame();
      drive_frame("frame_01001", 16'b01001, 5, -1, -1, -1, 0, -1, 3);
   endtask

   task automatic test_ignored_load();
      // Zero-length request: nothing may start.
      pattern = 16'hFFFF;
      len     = '0;
      load    = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         @(posedge clk);
         #1;
         load = (k < 3);
         #1;
         n_total++;
         if (obs_v !== IDLE_V) $display("FAIL len_zero cyc%0d: got %b want %b", k, obs_v, IDLE_V);
         else n_pass++;
      end
      // A second load during the transfer must not disturb it.
      drive_frame("load_in_shift", 16'hA5C3, 9, -1, -1, -1, 0, 6, 2);
   endtask

   task automatic test_stop();
      drive_frame("stop_cyc7", 16'b01001, 5, 7, -1, -1, 0, -1, 18);
      // stop and load together in IDLE: stop wins.
      pattern = 16'h00FF;
      len     = 5'd8;
      load    = 1'b1;
      stop    = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         @(posedge clk);
         #1;
         load = 1'b0;
         stop = 1'b0;
         #1;
         n_total++;
         if (obs_v !== IDLE_V) $display("FAIL stop_beats_load cyc%0d: got %b want %b", k, obs_v, IDLE_V);
         else n_pass++;
      end
   endtask

   task automatic test_enable();
      drive_frame("ena_gap", 16'b01001, 5, -1, -1, 6, 10, -1, 2);
      drive_frame("ena_gap_on_strobe", 16'h0F0F, 6, -1, -1, 9, 3, -1, 2);
   endtask

   task automatic test_reset_mid_and_clamp();
      drive_frame("rst_cyc10", 16'b01001, 5, -1, 10, -1, 0, -1, 8);
      drive_frame("len20_clamp", 16'hC3A5, 20, -1, -1, -1, 0, -1, 2);
   endtask

   task automatic test_random();
      for (int i = 0; i < 8; i++) begin
         int l_in, l, off_at, off_n, rl;
         logic [15:0] p;
         p      = 16'($urandom);
         l_in   = $urandom_range(1, 20);
         l      = (l_in > WIDTH) ? WIDTH : l_in;
         off_n  = $urandom_range(0, 6);
         off_at = $urandom_range(1, l * DIV);
         rl     = ($urandom_range(0, 1) == 1) ? $urandom_range(1, l * DIV) : -1;
         drive_frame("random", p, l_in, -1, -1, off_at, off_n, rl, 2);
      end
   endtask

`ifdef SERIAL_SRC_LOOP_EN
   task automatic test_loop();
      int j, idx, phase, dones_exp, dones_got;
      bit aborted, stop_prev;
      logic [15:0] p;
      logic [8:0] e;
      p = 16'($urandom);
      loop_mode = 1'b1;
      pattern = p;
      len  = 5'd3;
      load = 1'b1;
      stop = 1'b0;
      j = 0;
      aborted = 1'b0;
      stop_prev = 1'b0;
      dones_exp = 0;
      dones_got = 0;
      for (int k = 1; k <= 45; k++) begin
         @(posedge clk);
         #1;
         if (k > 1) begin
            if (stop_prev) aborted = 1'b1;
            else if (!aborted) j++;
         end
         load = 1'b0;
         stop = (k == 40);
         stop_prev = stop;
         #1;
         if (aborted) begin
            e = IDLE_V;
         end else begin
            phase = j % (3 * DIV);
            idx = phase / DIV;
            e = {p[2-idx], phase % DIV == 0, 1'b1, j > 0 && phase == 0, LEN_W'(2 - idx)};
         end
         if (e[5]) dones_exp++;
         if (done) dones_got++;
         n_total++;
         if (obs_v !== e) $display("FAIL loop cyc%0d: got %b want %b", k, obs_v, e);
         else n_pass++;
      end
      n_total++;
      if (dones_got !== dones_exp) $display("FAIL loop_done_count: got %0d want %0d", dones_got, dones_exp);
      else n_pass++;
      loop_mode = 1'b0;
      stop = 1'b0;
   endtask
`endif

   initial begin
      n_total = 0;
      n_pass  = 0;
      rst     = 1'b1;
      ena     = 1'b1;
      load    = 1'b0;
      stop    = 1'b0;
      pattern = '0;
      len     = '0;
`ifdef SERIAL_SRC_LOOP_EN
      loop_mode = 1'b0;
`endif
      test_reset();
      test_frame();
      test_ignored_load();
      test_stop();
      test_enable();
      test_reset_mid_and_clamp();
      test_random();
`ifdef SERIAL_SRC_LOOP_EN
      test_loop();
`endif
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
